// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 async read ports, 2 sync write ports (port 0 has priority),
// write-to-read bypass, optional hard-zero r0 and a sequenced bulk-clear engine.

module rf_cell #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end

endmodule

module reg_file_mp #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    input  logic          wr_en0,
    input  logic [AW-1:0] wr_addr0,
    input  logic [DW-1:0] dat_in0,
    input  logic          wr_en1,
    input  logic [AW-1:0] wr_addr1,
    input  logic [DW-1:0] dat_in1,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam int DEPTH = 1 << AW;
    localparam int RD_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       cnt, cnt_nxt;
    logic                clearing;

    logic [DEPTH-1:0][DW-1:0]    regs;
    logic [DEPTH-1:0]            cell_we;
    logic [DEPTH-1:0][DW-1:0]    cell_d;
    logic [RD_PORTS-1:0][AW-1:0] rd_addr;
    logic [RD_PORTS-1:0][DW-1:0] rd_dat;

    assign clearing = (state == CLEAR);

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == {AW{1'b1}}) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode straight from the state flops, so they are glitch-free
    // and mutually exclusive by construction.
    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);

    // ---------------- storage ----------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(i);

        if (ZERO_R0 != 0 && i == 0) begin : g_zero
            // r0 stays at its reset value forever
            assign cell_we[i] = 1'b0;
            assign cell_d[i]  = '0;
        end else begin : g_wr
            logic hit0, hit1;
            assign hit0 = wr_en0 && (wr_addr0 == IDX);
            assign hit1 = wr_en1 && (wr_addr1 == IDX);

            always_comb begin
                cell_we[i] = 1'b0;
                cell_d[i]  = '0;
                if (clearing) begin
                    cell_we[i] = (cnt == IDX);
                end else begin
                    cell_we[i] = hit0 | hit1;
                    cell_d[i]  = hit0 ? dat_in0 : dat_in1;
                end
            end
        end

        rf_cell #(.DW(DW)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (cell_we[i]),
            .d     (cell_d[i]),
            .q     (regs[i])
        );
    end

    // ---------------- read ports ----------------
    assign rd_addr[0] = rd_addrA;
    assign rd_addr[1] = rd_addrB;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [DW-1:0] q;

        always_comb begin
            q = regs[rd_addr[p]];
            // Forwarding order mirrors write priority: port 0 beats port 1.
            if (BYPASS != 0 && !clearing) begin
                if (wr_en0 && wr_addr0 == rd_addr[p])      q = dat_in0;
                else if (wr_en1 && wr_addr1 == rd_addr[p]) q = dat_in1;
            end
            if (ZERO_R0 != 0 && rd_addr[p] == '0) q = '0;
        end

        assign rd_dat[p] = q;
    end

    assign datA_out = rd_dat[0];
    assign datB_out = rd_dat[1];

endmodule
